// File: rtl/pc_redirect_unit.sv
// Fetch-stage program counter with exception/ERET redirection, a one-entry
// pending-redirect buffer for redirects raised under stall, and fetch address-error flag.
//
// state | meaning
// IDLE  | no redirect waiting; pc follows pc_src when not stalled
// PEND  | a redirect arrived during a stall; pend_target applied on release
module pc_redirect_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(32'h0000_4180),
  parameter logic [WIDTH-1:0] IMEM_LO  = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] IMEM_HI  = WIDTH'(32'h0000_6FFC),
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned JIMM_W = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        pc_src,
  input  logic [WIDTH-1:0]  d_pc,
  input  logic [IMM_W-1:0]  br_imm,
  input  logic [JIMM_W-1:0] j_imm,
  input  logic [WIDTH-1:0]  ra,
  input  logic              stall,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [WIDTH-1:0]  epc,
  output logic [WIDTH-1:0]  pc_out,
  output logic              fetch_adel,
  output logic              redirect_pend
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  localparam int unsigned JF_W = WIDTH - 6;

  localparam logic [2:0] SRC_BR  = 3'd1;
  localparam logic [2:0] SRC_J   = 3'd2;
  localparam logic [2:0] SRC_REG = 3'd3;

  logic [0:0]       state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pend_target;

  logic [WIDTH-1:0] seq_target;
  logic [WIDTH-1:0] dpc_plus4;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] br_target;
  logic [JF_W-1:0]  j_field;
  logic [WIDTH-1:0] j_target;
  logic [WIDTH-1:0] next_pc;
  logic             is_redirect;

  assign seq_target = pc + WIDTH'(4);
  assign dpc_plus4  = d_pc + WIDTH'(4);
  assign br_off     = {{(WIDTH-IMM_W){br_imm[IMM_W-1]}}, br_imm} << 2;
  assign br_target  = dpc_plus4 + br_off;
  // Jump index is zero-extended (or truncated) to whatever fits below the 4-bit region.
  assign j_field    = JF_W'(j_imm);
  assign j_target   = {dpc_plus4[WIDTH-1:WIDTH-4], j_field, 2'b00};

  always_comb begin
    next_pc     = seq_target;
    is_redirect = 1'b0;
    case (pc_src)
      SRC_BR:  begin next_pc = br_target; is_redirect = 1'b1; end
      SRC_J:   begin next_pc = j_target;  is_redirect = 1'b1; end
      SRC_REG: begin next_pc = ra;        is_redirect = 1'b1; end
      default: begin next_pc = seq_target; is_redirect = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      state       <= IDLE;
      pend_target <= '0;
    end else if (exc_req) begin
      pc    <= EXC_PC;
      state <= IDLE;
    end else if (eret_req) begin
      pc    <= epc;
      state <= IDLE;
    end else if (stall) begin
      // Only the first redirect seen during a stall is kept.
      if (state == IDLE && is_redirect) begin
        pend_target <= next_pc;
        state       <= PEND;
      end
    end else if (state == PEND) begin
      pc    <= pend_target;
      state <= IDLE;
    end else begin
      pc <= next_pc;
    end
  end

  assign pc_out        = pc;
  assign redirect_pend = (state == PEND);
  assign fetch_adel    = (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: sequential fetch, branch/jump targets,
// stalled-redirect buffering, exception/ERET priority and address-error flagging.
module tb_pc_redirect_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  pc_src;
  logic [31:0] d_pc;
  logic [15:0] br_imm;
  logic [25:0] j_imm;
  logic [31:0] ra;
  logic        stall;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc_out;
  logic        fetch_adel;
  logic        redirect_pend;

  int checks = 0;
  int errors = 0;

  pc_redirect_unit dut (
    .clk(clk), .reset(reset), .pc_src(pc_src), .d_pc(d_pc), .br_imm(br_imm),
    .j_imm(j_imm), .ra(ra), .stall(stall), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .pc_out(pc_out), .fetch_adel(fetch_adel), .redirect_pend(redirect_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; pc_src = 3'd0; d_pc = '0; br_imm = '0; j_imm = '0; ra = '0;
    stall = 1'b0; exc_req = 1'b0; eret_req = 1'b0; epc = '0;

    // asynchronous reset before any clock edge
    #3 reset = 1'b0;
    #1;
    check("reset_pc", pc_out, 32'h3000);
    check("reset_pend", {31'b0, redirect_pend}, 32'd0);
    check("reset_adel", {31'b0, fetch_adel}, 32'd0);
    step();
    check("reset_hold", pc_out, 32'h3000);
    reset = 1'b1;

    step(); step(); step();
    check("seq_pc", pc_out, 32'h300C);
    check("seq_adel", {31'b0, fetch_adel}, 32'd0);

    d_pc = 32'h3010; br_imm = 16'hFFFC; pc_src = 3'd1;
    step();
    check("branch_pc", pc_out, 32'h3004);

    pc_src = 3'd2; j_imm = 26'h0000C40; d_pc = 32'h3000;
    step();
    check("jump_pc", pc_out, 32'h3100);

    stall = 1'b1; pc_src = 3'd3; ra = 32'h3200;
    step();
    check("stall_hold", pc_out, 32'h3100);
    check("stall_pend", {31'b0, redirect_pend}, 32'd1);
    ra = 32'h3400;
    step();
    check("stall_second_hold", pc_out, 32'h3100);
    check("stall_second_pend", {31'b0, redirect_pend}, 32'd1);
    stall = 1'b0;
    step();
    check("release_pc", pc_out, 32'h3200);
    check("release_pend", {31'b0, redirect_pend}, 32'd0);
    pc_src = 3'd0;
    step();
    check("after_release_seq", pc_out, 32'h3204);

    stall = 1'b1; pc_src = 3'd3; ra = 32'h3300;
    step();
    check("pend_setup", {31'b0, redirect_pend}, 32'd1);
    exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3020;
    step();
    check("exc_pc", pc_out, 32'h4180);
    check("exc_pend", {31'b0, redirect_pend}, 32'd0);
    check("exc_adel", {31'b0, fetch_adel}, 32'd0);
    exc_req = 1'b0;
    step();
    check("eret_pc", pc_out, 32'h3020);
    check("eret_pend", {31'b0, redirect_pend}, 32'd0);
    eret_req = 1'b0; stall = 1'b0; pc_src = 3'd0;
    step();
    check("discarded_pend_seq", pc_out, 32'h3024);

    pc_src = 3'd3; ra = 32'h3002;
    step();
    check("adel_misaligned", {31'b0, fetch_adel}, 32'd1);
    ra = 32'h7000;
    step();
    check("adel_above", {31'b0, fetch_adel}, 32'd1);
    ra = 32'h6FFC;
    step();
    check("adel_hi_edge", {31'b0, fetch_adel}, 32'd0);
    ra = 32'h2FFC;
    step();
    check("adel_below", {31'b0, fetch_adel}, 32'd1);
    pc_src = 3'd5;
    step();
    check("reserved_seq_pc", pc_out, 32'h3000);
    check("lo_edge_adel", {31'b0, fetch_adel}, 32'd0);

    pc_src = 3'd3; ra = 32'hFFFF_FFFC;
    step();
    pc_src = 3'd0;
    step();
    check("wrap_pc", pc_out, 32'h0);
    check("wrap_adel", {31'b0, fetch_adel}, 32'd1);

    stall = 1'b1; pc_src = 3'd3; ra = 32'h3500;
    step();
    check("pend_before_reset", {31'b0, redirect_pend}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_pc", pc_out, 32'h3000);
    check("async_reset_pend", {31'b0, redirect_pend}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
